// File: rtl/aether_pifo_sched_ctrl.sv
// aether_pifo_sched_ctrl: arbitrates enqueue requesters and dequeue requests
// onto a single push/pop port of an external PIFO tree. It tracks the tree
// occupancy, buffers pop results in a small FWFT FIFO and can flush the tree
// through a RUN -> DRAIN -> SETTLE sequence.
//
// Handshakes: a valid/ready pair transfers exactly in a cycle where both are
// high. Requesters hold i_enq_valid/i_enq_data until o_enq_ready[k] is seen.
// i_deq_req is held until o_deq_req_ready. o_deq_valid/o_deq_data stay stable
// until i_deq_ready is seen. Push and pop issue are combinational from the
// current inputs and state, so a grant never lags its request by a cycle.
module aether_pifo_sched_ctrl #(
    parameter int PTW         = 16,
    parameter int MTW         = 32,
    parameter int NREQ        = 4,
    parameter int CAPACITY    = 1024,
    parameter int POP_LAT     = 2,
    parameter int RFIFO_DEPTH = 4,
    parameter int STARVE_MAX  = 8
) (
    input  logic                              i_clk,
    input  logic                              i_arst_n,
    input  logic [NREQ-1:0]                   i_enq_valid,
    input  logic [NREQ*(MTW+PTW)-1:0]         i_enq_data,
    output logic [NREQ-1:0]                   o_enq_ready,
    input  logic                              i_deq_req,
    output logic                              o_deq_req_ready,
    output logic                              o_deq_valid,
    output logic [MTW+PTW-1:0]                o_deq_data,
    input  logic                              i_deq_ready,
    output logic                              o_pifo_push,
    output logic                              o_pifo_pop,
    output logic [MTW+PTW-1:0]                o_pifo_data,
    input  logic [MTW+PTW-1:0]                i_pifo_data,
    input  logic                              i_drain,
    output logic                              o_drain_busy,
    output logic [$clog2(CAPACITY+1)-1:0]     o_count,
    output logic                              o_full,
    output logic                              o_empty
);

    localparam int W   = MTW + PTW;
    localparam int CW  = $clog2(CAPACITY + 1);
    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW  = $clog2(STARVE_MAX + 1);
    localparam int AW  = (RFIFO_DEPTH > 1) ? $clog2(RFIFO_DEPTH) : 1;
    localparam int FCW = $clog2(RFIFO_DEPTH + 1);

    localparam logic [CW-1:0]      CAP_C      = CW'(CAPACITY);
    localparam logic [SW-1:0]      STARVE_C   = SW'(STARVE_MAX);
    localparam logic [AW-1:0]      LAST_SLOT  = AW'(RFIFO_DEPTH - 1);
    localparam logic [PW-1:0]      LAST_REQ   = PW'(NREQ - 1);
    // Every shift stage except the last; a pop in the last stage returns its
    // data this cycle and is no longer outstanding after the clock edge.
    localparam logic [POP_LAT-1:0] EARLY_MASK = {POP_LAT{1'b1}} >> 1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SETTLE = 2'd2
    } state_e;

    state_e                 state_q;
    logic                   busy_q;
    logic [CW-1:0]          count_q,    count_d;
    logic [PW-1:0]          rr_ptr_q,   rr_ptr_d;
    logic [SW-1:0]          starve_q,   starve_d;
    logic [POP_LAT-1:0]     pop_sr_q,   pop_sr_d;   // every pop issued
    logic [POP_LAT-1:0]     keep_sr_q,  keep_sr_d;  // pops whose result is kept
    logic [W-1:0]           fifo_mem_q [RFIFO_DEPTH];
    logic [AW-1:0]          rd_ptr_q,   rd_ptr_d;
    logic [AW-1:0]          wr_ptr_q,   wr_ptr_d;
    logic [FCW-1:0]         fifo_cnt_q, fifo_cnt_d;

    logic                   gnt_found;
    logic [PW-1:0]          gnt_idx;
    int                     cand;
    int                     infl_cnt;
    logic                   fifo_room;
    logic                   push_elig, pop_elig, drain_pop, starve_hit;
    logic                   do_push, do_pop_run, do_pop;
    logic                   fifo_wr, fifo_rd;

    // Round-robin search for the first valid requester at or after the pointer.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = (int'(rr_ptr_q) + i) % NREQ;
            if (!gnt_found && i_enq_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = PW'(cand);
            end
        end
    end

    // Result FIFO credit: held entries plus kept pops still in the tree.
    always_comb begin
        infl_cnt = 0;
        for (int i = 0; i < POP_LAT; i++) begin
            if (keep_sr_q[i]) begin
                infl_cnt = infl_cnt + 1;
            end
        end
        fifo_room = (int'(fifo_cnt_q) + infl_cnt) < RFIFO_DEPTH;
    end

    // Issue arbitration; reset gates all issue so nothing reaches the tree.
    always_comb begin
        push_elig  = i_arst_n && (state_q == ST_RUN) && gnt_found && (count_q < CAP_C);
        pop_elig   = i_arst_n && (state_q == ST_RUN) && i_deq_req &&
                     (count_q != '0) && fifo_room;
        drain_pop  = i_arst_n && (state_q == ST_DRAIN) && (count_q != '0);
        starve_hit = (starve_q == STARVE_C);
        do_push    = push_elig && (!pop_elig || starve_hit);
        do_pop_run = pop_elig && !do_push;
        do_pop     = do_pop_run || drain_pop;
    end

    // Drive the tree and requester-facing handshake outputs.
    always_comb begin
        o_enq_ready = '0;
        o_pifo_data = '0;
        if (do_push) begin
            o_enq_ready[gnt_idx] = 1'b1;
            o_pifo_data          = i_enq_data[gnt_idx*W +: W];
        end
        o_pifo_push     = do_push;
        o_pifo_pop      = do_pop;
        o_deq_req_ready = do_pop_run;
    end

    // Next-state for counters, pointer, starvation and in-flight tracking.
    always_comb begin
        count_d = count_q;
        if (do_push) begin
            count_d = count_q + 1'b1;
        end else if (do_pop) begin
            count_d = count_q - 1'b1;
        end

        rr_ptr_d = rr_ptr_q;
        if (do_push) begin
            rr_ptr_d = (gnt_idx == LAST_REQ) ? '0 : gnt_idx + 1'b1;
        end

        starve_d = starve_q;
        if (do_push) begin
            starve_d = '0;
        end else if (do_pop_run && push_elig && !starve_hit) begin
            starve_d = starve_q + 1'b1;
        end

        pop_sr_d     = '0;
        keep_sr_d    = '0;
        pop_sr_d[0]  = do_pop;
        keep_sr_d[0] = do_pop_run;
        for (int i = 1; i < POP_LAT; i++) begin
            pop_sr_d[i]  = pop_sr_q[i-1];
            keep_sr_d[i] = keep_sr_q[i-1];
        end
    end

    // Result FIFO pointer and occupancy next-state.
    always_comb begin
        fifo_wr    = keep_sr_q[POP_LAT-1];
        fifo_rd    = o_deq_valid && i_deq_ready;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (fifo_wr) begin
            wr_ptr_d = (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + 1'b1;
        end
        if (fifo_rd) begin
            rd_ptr_d = (rd_ptr_q == LAST_SLOT) ? '0 : rd_ptr_q + 1'b1;
        end
        if (fifo_wr && !fifo_rd) begin
            fifo_cnt_d = fifo_cnt_q + 1'b1;
        end else if (!fifo_wr && fifo_rd) begin
            fifo_cnt_d = fifo_cnt_q - 1'b1;
        end
    end

    // Control and tracking registers; reset drops all in-flight results.
    always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
            count_q    <= '0;
            rr_ptr_q   <= '0;
            starve_q   <= '0;
            pop_sr_q   <= '0;
            keep_sr_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            count_q    <= count_d;
            rr_ptr_q   <= rr_ptr_d;
            starve_q   <= starve_d;
            pop_sr_q   <= pop_sr_d;
            keep_sr_q  <= keep_sr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // Result FIFO storage; contents are qualified by the occupancy count.
    always_ff @(posedge i_clk) begin
        if (fifo_wr) begin
            fifo_mem_q[wr_ptr_q] <= i_pifo_data;
        end
    end

    // Drain FSM with registered busy flag.
    always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (i_drain) begin
                        state_q <= ST_DRAIN;
                        busy_q  <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (count_d == '0) begin
                        state_q <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if ((pop_sr_q & EARLY_MASK) == '0) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_deq_valid  = (fifo_cnt_q != '0);
    assign o_deq_data   = fifo_mem_q[rd_ptr_q];
    assign o_drain_busy = busy_q;
    assign o_count      = count_q;
    assign o_full       = (count_q == CAP_C);
    assign o_empty      = (count_q == '0);

endmodule

// File: doc/aether_pifo_sched_ctrl.md
AETHER_PIFO_SCHED_CTRL -- requirements
Module: aether_pifo_sched_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): PTW, 16, priority tag width; MTW, 32, metadata width; NREQ, 4, enqueue requesters; CAPACITY, 1024, max entries held by the tree; POP_LAT, 2, cycles from o_pifo_pop to valid i_pifo_data; RFIFO_DEPTH, 4, result FIFO entries; STARVE_MAX, 8, consecutive pop wins before push is forced.
REQ-002 Ports SHALL be (name, direction, width, meaning); W = MTW+PTW, CW = clog2(CAPACITY+1):
- i_clk  in  1  clock; single clock domain.
- i_arst_n  in  1  reset; synchronous, active-low.
- i_enq_valid  in  NREQ  per-requester push request.
- i_enq_data  in  NREQ*W  per-requester entry; requester k at bits [k*W +: W].
- o_enq_ready  out  NREQ  one-hot push grant.
- i_deq_req  in  1  dequeue request.
- o_deq_req_ready  out  1  dequeue request accepted, pop issued.
- o_deq_valid  out  1  result FIFO head valid.
- o_deq_data  out  W  result FIFO head.
- i_deq_ready  in  1  consumer accepts head.
- o_pifo_push  out  1  push to tree.
- o_pifo_pop  out  1  pop to tree.
- o_pifo_data  out  W  push entry to tree.
- i_pifo_data  in  W  pop result from tree.
- i_drain  in  1  flush request pulse.
- o_drain_busy  out  1  drain in progress.
- o_count  out  CW  entries in tree.
- o_full  out  1  o_count == CAPACITY.
- o_empty  out  1  o_count == 0.

Function
REQ-003 At most one of o_pifo_push / o_pifo_pop SHALL be high per cycle; issue is combinational from current inputs and state, zero added latency.
REQ-004 Push eligible: state RUN, any i_enq_valid, count < CAPACITY.
REQ-005 Pop eligible: state RUN, i_deq_req, count > 0, (result FIFO occupancy + pops in flight) < RFIFO_DEPTH.
REQ-006 Both eligible: pop wins, unless starve counter == STARVE_MAX, in which case push wins.
REQ-007 Starve counter: +1 on each pop win while push eligible (saturate at STARVE_MAX); cleared on any push issue.
REQ-008 Push grant SHALL be round-robin over requesters; search starts at pointer; after a grant to k, pointer becomes (k+1) mod NREQ; pointer holds when no push issues.
REQ-009 o_enq_ready[k] high only in the cycle requester k is pushed; o_pifo_data = i_enq_data of k then, else 0.
REQ-010 o_deq_req_ready == o_pifo_pop in RUN; one accepted request yields exactly one result.
REQ-011 Pops SHALL be tracked by a POP_LAT-deep valid shift register; i_pifo_data SHALL be written to the result FIFO exactly POP_LAT cycles after issue; FIFO never overflows by REQ-005.
REQ-012 Result FIFO is first-word-fall-through; head pops on o_deq_valid && i_deq_ready; simultaneous write and read SHALL be supported when full or empty.
REQ-013 o_count: +1 on push, -1 on pop, registered; o_full/o_empty derived from the registered count.
REQ-014 FSM states SHALL be RUN, DRAIN, SETTLE.
- RUN -> DRAIN on i_drain.
- DRAIN: all o_enq_ready=0, o_deq_req_ready=0; issue an internal pop every cycle while count>0; results of these pops are discarded and not written to the FIFO.
- DRAIN -> SETTLE when count==0 (same cycle as last pop or later).
- SETTLE -> RUN when no pops in flight.
- i_drain outside RUN ignored.
REQ-015 o_drain_busy high in DRAIN and SETTLE; result FIFO contents already present at drain entry SHALL still be delivered.

Reset
REQ-016 On i_clk edge with i_arst_n=0: state RUN, count 0, RR pointer 0, starve 0, in-flight cleared, result FIFO emptied.
REQ-017 Outputs during and after reset: o_deq_valid 0, o_empty 1, o_full 0, o_drain_busy 0, o_pifo_push/pop 0, o_enq_ready 0.
REQ-018 Reset mid-operation: in-flight results SHALL be discarded; the tree is reset in the same cycle by the system.

Verification
REQ-019 All 4 requesters valid for 8 cycles, no deq -> grants 0,1,2,3,0,1,2,3; o_count 8.
REQ-020 Count=3, i_deq_req held, consumer ready -> 3 pops; o_deq_valid exactly POP_LAT(+1 FIFO) cycles after each; 4th request not accepted; o_empty=1.
REQ-021 Push and deq continuously valid, count>0 -> pattern of 8 pops then 1 push, repeating.
REQ-022 i_deq_ready=0, deq requested -> exactly 4 pops issued, then o_deq_req_ready=0 until a head is consumed.
REQ-023 count=5, i_drain pulse -> 5 discarded pops, o_drain_busy high for 5+POP_LAT cycles, return to RUN with count 0, no o_deq_valid.
REQ-024 Reset asserted with 2 pops in flight and full result FIFO -> next cycle o_deq_valid 0, o_count 0; no late writes.
